// File: rtl/conv_relu_pkg.sv
// rtl/conv_relu_pkg.sv - shared constants, Sobel-X kernel, FSM state type and MAC helper
// Contents: frame/pixel/result widths, counter widths, KERNEL coefficients
// (row-major, top->bottom, left->right), state_t {IDLE, RUN, FLUSH}, coef_mul().
package conv_relu_pkg;

    localparam int IMG_W     = 32;
    localparam int IMG_H     = 32;
    localparam int PIX_W     = 8;
    localparam int OUT_W     = 22;
    localparam int COL_W     = $clog2(IMG_W);
    localparam int ROW_W     = $clog2(IMG_H);
    // |sum| <= 4*255 = 1020, so 12 signed bits hold every partial sum.
    localparam int SUM_W     = 12;
    localparam int N_RESULTS = (IMG_W - 2) * (IMG_H - 2);
    localparam int CNT_W     = $clog2(N_RESULTS + 1);

    localparam logic signed [2:0] KERNEL [0:8] = '{
        3'sd1, 3'sd0, -3'sd1,
        3'sd2, 3'sd0, -3'sd2,
        3'sd1, 3'sd0, -3'sd1
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    // Signed coefficient times zero-extended pixel.
    function automatic logic signed [SUM_W-1:0] coef_mul(input logic signed [2:0] k,
                                                         input logic [PIX_W-1:0] p);
        logic signed [SUM_W-1:0] ks;
        logic signed [SUM_W-1:0] ps;
        ks = {{(SUM_W-3){k[2]}}, k};
        ps = {{(SUM_W-PIX_W){1'b0}}, p};
        return ks * ps;
    endfunction

endpackage

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - two line buffers + 3x3 window register + window-valid flag
// Ports: clk, rst (async active-low), clr_i (drop pending window-valid),
//        accept_i (pixel accepted), pixel_i, row_i/col_i (position of accepted pixel),
//        win_o (9 pixels, index = row*3+col, row 0 = oldest line, col 0 = leftmost),
//        win_valid_o (window holds a full valid-mode neighbourhood).
module conv_window_gen
    import conv_relu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 accept_i,
    input  logic [PIX_W-1:0]     pixel_i,
    input  logic [ROW_W-1:0]     row_i,
    input  logic [COL_W-1:0]     col_i,
    output logic [9*PIX_W-1:0]   win_o,
    output logic                 win_valid_o
);

    // lb0 holds row r-1, lb1 holds row r-2, both indexed by column.
    logic [PIX_W-1:0] lb0_q [IMG_W];
    logic [PIX_W-1:0] lb1_q [IMG_W];
    logic [PIX_W-1:0] win_q [3][3];
    logic             win_valid_q;

    // Storage needs no reset: window-valid only rises once both lines are
    // rewritten by the current frame.
    always_ff @(posedge clk) begin
        if (accept_i) begin
            lb1_q[col_i] <= lb0_q[col_i];
            lb0_q[col_i] <= pixel_i;
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1_q[col_i];
            win_q[1][2] <= lb0_q[col_i];
            win_q[2][2] <= pixel_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid_q <= 1'b0;
        end else if (clr_i) begin
            win_valid_q <= 1'b0;
        end else begin
            win_valid_q <= accept_i && (row_i >= ROW_W'(2)) && (col_i >= COL_W'(2));
        end
    end

    always_comb begin
        win_o = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_o[(r*3+c)*PIX_W +: PIX_W] = win_q[r][c];
            end
        end
    end

    assign win_valid_o = win_valid_q;

endmodule

// File: rtl/conv_relu_top.sv
// rtl/conv_relu_top.sv - streaming 3x3 Sobel-X convolution + ReLU over a 32x32 frame
// Ports: clk, rst (async active-low), start_signal (arm/restart frame),
//        pixel_valid/pixel_in (raster-order pixels), result_out/result_valid
//        (900 valid-mode results, 3 cycles after the accepting cycle),
//        done_signal (with the 900th result).
// Build option: CONV_RELU_SAT8_EN clamps the ReLU output to 255.
module conv_relu_top
    import conv_relu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_signal,
    input  logic             pixel_valid,
    input  logic [PIX_W-1:0] pixel_in,
    output logic [OUT_W-1:0] result_out,
    output logic             result_valid,
    output logic             done_signal
);

    state_t                  state_q;
    logic [ROW_W-1:0]        row_q;
    logic [COL_W-1:0]        col_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    done_q;
    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] sum_q;
    logic                    sum_valid_q;
    logic [OUT_W-1:0]        relu_d;
    logic [OUT_W-1:0]        result_q;
    logic                    result_valid_q;
    logic [9*PIX_W-1:0]      win;
    logic                    win_valid;
    logic                    accept;
    logic                    last_pixel;
    logic                    last_result;

    // A start pulse wins over a pixel in the same cycle.
    assign accept      = (state_q == RUN) && pixel_valid && !start_signal;
    assign last_pixel  = (row_q == ROW_W'(IMG_H-1)) && (col_q == COL_W'(IMG_W-1));
    assign last_result = sum_valid_q && (cnt_q == CNT_W'(N_RESULTS-1));

    conv_window_gen u_window (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (start_signal),
        .accept_i    (accept),
        .pixel_i     (pixel_in),
        .row_i       (row_q),
        .col_i       (col_q),
        .win_o       (win),
        .win_valid_o (win_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (start_signal) begin
            state_q <= RUN;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            // cnt_q counts results entering the output register, so done
            // lines up with the 900th result_valid.
            done_q <= last_result;
            if (sum_valid_q) begin
                cnt_q <= last_result ? '0 : cnt_q + 1'b1;
            end
            case (state_q)
                IDLE: state_q <= IDLE;
                RUN: begin
                    if (accept) begin
                        if (col_q == COL_W'(IMG_W-1)) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        if (last_pixel) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (last_result) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 9; i++) begin
            sum_d = sum_d + coef_mul(KERNEL[i], win[i*PIX_W +: PIX_W]);
        end
    end

    always_comb begin
        relu_d = '0;
        if (!sum_q[SUM_W-1]) begin
            relu_d = {{(OUT_W-SUM_W){1'b0}}, sum_q};
`ifdef CONV_RELU_SAT8_EN
            if (sum_q > SUM_W'(255)) begin
                relu_d = OUT_W'(255);
            end
`endif
        end
    end

    // Stages after the window run every cycle; a start pulse kills in-flight results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q          <= '0;
            sum_valid_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            sum_valid_q    <= win_valid && !start_signal;
            result_valid_q <= sum_valid_q && !start_signal;
            if (win_valid) begin
                sum_q <= sum_d;
            end
            if (sum_valid_q) begin
                result_q <= relu_d;
            end
        end
    end

    assign result_out   = result_q;
    assign result_valid = result_valid_q;
    assign done_signal  = done_q;

endmodule

// File: tb/tb_conv_relu_top.sv
// tb/tb_conv_relu_top.sv - randomized self-checking bench for conv_relu_top (honours CONV_RELU_SAT8_EN)
module tb_conv_relu_top;

    localparam int W  = 32;
    localparam int OW = 30;
`ifdef CONV_RELU_SAT8_EN
    localparam int PEAK = 255;
`else
    localparam int PEAK = 1020;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_signal;
    logic        pixel_valid;
    logic [7:0]  pixel_in;
    logic [21:0] result_out;
    logic        result_valid;
    logic        done_signal;

    always #5 clk = ~clk;

    conv_relu_top dut (
        .clk          (clk),
        .rst          (rst),
        .start_signal (start_signal),
        .pixel_valid  (pixel_valid),
        .pixel_in     (pixel_in),
        .result_out   (result_out),
        .result_valid (result_valid),
        .done_signal  (done_signal)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int frame [W][W];
    int exp_q [$];
    int acc_q [$];
    int got [OW*OW];
    int nres = 0;
    int spur = 0;
    int ecnt = 0;

    task automatic check(input string tag, input longint actual, input longint expected);
        chk_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    initial forever begin
        @(posedge clk);
        ecnt++;
    end

    // Monitor: every result is matched in order against the reference queue.
    // A pixel accepted at edge a has its result visible just after edge a+2,
    // i.e. in the cycle whose closing edge (a+3) is three cycles later.
    initial forever begin
        int ev;
        int a;
        @(posedge clk);
        #1;
        if (result_valid) begin
            nres++;
            if (exp_q.size() == 0) begin
                check("unexpected_result", result_out, -1);
            end else begin
                ev = exp_q.pop_front();
                check("result", result_out, ev);
                if (nres <= OW*OW) got[nres-1] = result_out;
            end
            if (acc_q.size() > 0) begin
                a = acc_q.pop_front();
                check("latency", ecnt, a + 2);
            end
            check("done", done_signal, (nres == OW*OW));
        end else if (done_signal) begin
            spur++;
        end
    end

    function automatic int gen_pix(input int pat, input int r, input int c);
        case (pat)
            1:       return (c < 16) ? 0 : 255;
            2:       return ((r + c) % 2 == 0) ? 255 : 0;
            3:       return (c < 16) ? 255 : 0;
            4:       return 31 - c;
            default: return int'($urandom_range(255, 0));
        endcase
    endfunction

    task automatic start_frame(input int pat);
        int s;
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                frame[r][c] = gen_pix(pat, r, c);
        @(negedge clk);
        pixel_valid  = 1'b0;
        start_signal = 1'b1;
        @(posedge clk);
        // The DUT takes the start here; whatever was in flight is discarded.
        exp_q.delete();
        acc_q.delete();
        nres = 0;
        spur = 0;
        for (int i = 0; i < OW*OW; i++) got[i] = -1;
        for (int oy = 0; oy < OW; oy++) begin
            for (int ox = 0; ox < OW; ox++) begin
                s = (frame[oy][ox] - frame[oy][ox+2])
                  + 2 * (frame[oy+1][ox] - frame[oy+1][ox+2])
                  + (frame[oy+2][ox] - frame[oy+2][ox+2]);
                if (s < 0) s = 0;
`ifdef CONV_RELU_SAT8_EN
                if (s > 255) s = 255;
`endif
                exp_q.push_back(s);
            end
        end
        @(negedge clk);
        start_signal = 1'b0;
    endtask

    // gap_mode: 0 none, 1 alternate valid/idle, 2 random 0..2 idle cycles
    task automatic send_pixels(input int gap_mode, input int n);
        int r;
        int c;
        int gaps;
        for (int i = 0; i < n; i++) begin
            r = i / W;
            c = i % W;
            gaps = (gap_mode == 1) ? ((i > 0) ? 1 : 0)
                 : (gap_mode == 2) ? int'($urandom_range(2, 0)) : 0;
            repeat (gaps) begin
                @(negedge clk);
                pixel_valid = 1'b0;
                pixel_in    = 8'($urandom);
            end
            @(negedge clk);
            pixel_valid = 1'b1;
            pixel_in    = 8'(frame[r][c]);
            @(posedge clk);
            #1;
            if (r >= 2 && c >= 2) acc_q.push_back(ecnt);
        end
        @(negedge clk);
        pixel_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check("drain_pending", exp_q.size(), 0);
        check("result_count", nres, OW*OW);
        check("spurious_done", spur, 0);
    endtask

    task automatic edge_cols(input string tag);
        int rows [3] = '{0, 17, 29};
        foreach (rows[k]) begin
            check({tag, "_col14"}, got[rows[k]*OW + 14], PEAK);
            check({tag, "_col15"}, got[rows[k]*OW + 15], PEAK);
            check({tag, "_col13"}, got[rows[k]*OW + 13], 0);
            check({tag, "_col16"}, got[rows[k]*OW + 16], 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b0;
        start_signal = 1'b0;
        pixel_valid  = 1'b0;
        pixel_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result_out", result_out, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_done", done_signal, 0);
        @(negedge clk);
        rst = 1'b1;

        // vertical edge: all negative sums clipped
        start_frame(1);
        send_pixels(0, W*W);
        wait_drain();
        check("vedge_col14", got[5*OW + 14], 0);
        check("vedge_last", got[OW*OW - 1], 0);

        // checkerboard with random stalls
        start_frame(2);
        send_pixels(2, W*W);
        wait_drain();
        check("checker_mid", got[450], 0);

        // inverted edge
        start_frame(3);
        send_pixels(0, W*W);
        wait_drain();
        edge_cols("iedge");

        // reverse ramp with pixel_valid toggling
        start_frame(4);
        send_pixels(1, W*W);
        wait_drain();
        check("ramp_first", got[0], 8);
        check("ramp_mid", got[450], 8);
        check("ramp_last", got[OW*OW - 1], 8);

        // back-to-back random frames
        start_frame(0);
        send_pixels(2, W*W);
        wait_drain();
        start_frame(0);
        send_pixels(0, W*W);
        wait_drain();

        // restart mid-frame: in-flight results must vanish
        start_frame(0);
        send_pixels(2, 300);
        start_frame(0);
        send_pixels(0, W*W);
        wait_drain();

        // asynchronous reset at pixel 500
        start_frame(0);
        send_pixels(0, 500);
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        nres = 0;
        spur = 0;
        #1;
        check("async_rst_result_out", result_out, 0);
        check("async_rst_result_valid", result_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("async_rst_done", done_signal, 0);
        @(negedge clk);
        rst = 1'b1;
        // pixels in IDLE must be ignored
        repeat (6) begin
            @(negedge clk);
            pixel_valid = 1'b1;
            pixel_in    = 8'($urandom);
        end
        @(negedge clk);
        pixel_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("idle_results", nres, 0);
        start_frame(3);
        send_pixels(2, W*W);
        wait_drain();
        edge_cols("post_rst_iedge");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
